// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_if
// Brief    : Request, core-side RAM and arbitrated RAM bundle for counter_sequencer.
// Revision : 1.0
// ============================================================================
interface counter_sequencer_if #(
  parameter int NCNT = 8
);
  logic [NCNT-1:0] inc_req;
  logic [14:0]     core_RAM_read_address;
  logic [14:0]     core_RAM_write_address;
  logic [14:0]     core_RAM_write_data;
  logic            core_RAM_write_en;
  logic [14:0]     RAM_read_data;
  logic [14:0]     RAM_read_address;
  logic [14:0]     RAM_write_address;
  logic [14:0]     RAM_write_data;
  logic            RAM_write_en;
  logic            core_stall;
  logic [NCNT-1:0] rupt_req;
  logic [NCNT-1:0] overrun;

  // Environment side: core, request sources and the RAM itself.
  modport master (
    output inc_req, core_RAM_read_address, core_RAM_write_address,
           core_RAM_write_data, core_RAM_write_en, RAM_read_data,
    input  RAM_read_address, RAM_write_address, RAM_write_data,
           RAM_write_en, core_stall, rupt_req, overrun
  );

  modport slave (
    input  inc_req, core_RAM_read_address, core_RAM_write_address,
           core_RAM_write_data, core_RAM_write_en, RAM_read_data,
    output RAM_read_address, RAM_write_address, RAM_write_data,
           RAM_write_en, core_stall, rupt_req, overrun
  );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Brief    : Steals RAM cycles from the core to increment ones' complement counters.
// Revision : 1.0
// ============================================================================
module counter_sequencer #(
  parameter logic [14:0] BASE_ADDR    = 15'o24,
  parameter int          NCNT         = 8,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          CASCADE_SRC  = 1,
  parameter int          CASCADE_DST  = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  counter_sequencer_if.slave  bus
);

  localparam int SELW = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int CNTW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [NCNT-1:0] r_pending;
  logic [NCNT-1:0] r_overrun;
  logic [NCNT-1:0] w_cascade;
  logic [NCNT-1:0] w_pend_base;
  logic [NCNT-1:0] w_clr;
  logic [14:0]     r_operand;
  logic [14:0]     w_inc_data;
  logic            w_ovf;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] w_sel_next;
  logic [CNTW-1:0] r_drain;
  logic            w_enter_read;
  logic            w_pend_any;
  logic [14:0]     w_cell_addr;

  assign w_cell_addr = BASE_ADDR + {{(15-SELW){1'b0}}, r_sel};

  // 15-bit ones' complement increment; -0 steps straight to +1.
  always_comb begin
    w_ovf = 1'b0;
    if (r_operand == 15'o37777) begin
      w_inc_data = 15'o00000;
      w_ovf      = 1'b1;
    end else if (r_operand == 15'o77777) begin
      w_inc_data = 15'o00001;
    end else begin
      w_inc_data = r_operand + 15'd1;
    end
  end

  always_comb begin
    w_cascade = '0;
    if (r_state == WRITE && w_ovf && r_sel == SELW'(CASCADE_SRC))
      w_cascade[CASCADE_DST] = 1'b1;
  end

  // Cascade requests are visible to selection in the same cycle, so a
  // chained cell is serviced right after its source without re-draining.
  assign w_pend_base = r_pending | w_cascade;
  assign w_pend_any  = |w_pend_base;

  always_comb begin
    w_sel_next = '0;
    for (int i = NCNT - 1; i >= 0; i--) begin
      if (w_pend_base[i]) w_sel_next = SELW'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_enter_read) w_clr[w_sel_next] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state          = r_state;
    w_enter_read          = 1'b0;
    bus.RAM_read_address  = bus.core_RAM_read_address;
    bus.RAM_write_address = bus.core_RAM_write_address;
    bus.RAM_write_data    = bus.core_RAM_write_data;
    bus.RAM_write_en      = bus.core_RAM_write_en;
    bus.core_stall        = 1'b0;
    bus.rupt_req          = '0;
    case (r_state)
      IDLE: begin
        if (w_pend_any) begin
          if (DRAIN_CYCLES == 0) begin
            w_next_state = READ;
            w_enter_read = 1'b1;
          end else begin
            w_next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        bus.core_stall = 1'b1;
        if (r_drain <= CNTW'(1)) begin
          w_next_state = READ;
          w_enter_read = 1'b1;
        end
      end
      READ: begin
        bus.core_stall       = 1'b1;
        bus.RAM_read_address = w_cell_addr;
        bus.RAM_write_en     = 1'b0;
        w_next_state         = WRITE;
      end
      WRITE: begin
        bus.core_stall        = 1'b1;
        bus.RAM_write_address = w_cell_addr;
        bus.RAM_write_data    = w_inc_data;
        bus.RAM_write_en      = 1'b1;
        if (w_ovf) bus.rupt_req[r_sel] = 1'b1;
        if (w_pend_any) begin
          w_next_state = READ;
          w_enter_read = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // A reset abandons any stolen cycle immediately, not just at the edge.
    if (!reset_n) begin
      w_next_state          = IDLE;
      w_enter_read          = 1'b0;
      bus.RAM_read_address  = bus.core_RAM_read_address;
      bus.RAM_write_address = bus.core_RAM_write_address;
      bus.RAM_write_data    = bus.core_RAM_write_data;
      bus.RAM_write_en      = bus.core_RAM_write_en;
      bus.core_stall        = 1'b0;
      bus.rupt_req          = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
      r_operand <= '0;
      r_sel     <= '0;
      r_drain   <= '0;
    end else begin
      // A new request always wins over a same-cycle clear of its bit.
      r_pending <= (w_pend_base & ~w_clr) | bus.inc_req;
      r_overrun <= r_overrun | (bus.inc_req & r_pending & ~w_clr);
      if (w_enter_read) r_sel <= w_sel_next;
      if (r_state == IDLE && w_next_state == DRAIN)
        r_drain <= CNTW'(DRAIN_CYCLES);
      else if (r_state == DRAIN)
        r_drain <= r_drain - CNTW'(1);
      if (r_state == READ) r_operand <= bus.RAM_read_data;
    end
  end

  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sequencer
// Brief    : Directed self-checking bench for counter_sequencer with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_counter_sequencer;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  logic [14:0] mem [0:63];
  logic [14:0] wq_addr [$];
  logic [14:0] wq_data [$];
  logic [7:0]  rq [$];

  counter_sequencer_if #(.NCNT(8)) bus ();

  counter_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.RAM_read_data = mem[bus.RAM_read_address[5:0]];

  always @(posedge clock) begin
    if (bus.RAM_write_en) begin
      mem[bus.RAM_write_address[5:0]] <= bus.RAM_write_data;
      wq_addr.push_back(bus.RAM_write_address);
      wq_data.push_back(bus.RAM_write_data);
    end
    if (|bus.rupt_req) rq.push_back(bus.rupt_req);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    rq.delete();
  endtask

  // Pulse a request and run until the stall window closes.
  task automatic service(input logic [7:0] req, output int stalls, output bit timeout);
    bus.inc_req = req;
    tick();
    bus.inc_req = '0;
    stalls  = 0;
    timeout = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (bus.core_stall) stalls++;
      else if (stalls > 0) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int stalls;
    bit timeout;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset with the core writing: port must pass through.
    reset_n                    = 1'b0;
    bus.inc_req                = '0;
    bus.core_RAM_read_address  = 15'o3;
    bus.core_RAM_write_address = 15'o2;
    bus.core_RAM_write_data    = 15'o1234;
    bus.core_RAM_write_en      = 1'b1;
    tick();
    tick();
    check("rst_stall",   {31'd0, bus.core_stall}, 32'd0);
    check("rst_rupt",    {24'd0, bus.rupt_req},   32'd0);
    check("rst_overrun", {24'd0, bus.overrun},    32'd0);
    check("rst_wen",     {31'd0, bus.RAM_write_en}, 32'd1);
    check("rst_waddr",   {17'd0, bus.RAM_write_address}, 32'o2);
    check("rst_raddr",   {17'd0, bus.RAM_read_address},  32'o3);
    bus.core_RAM_write_en = 1'b0;
    #1;
    check("rst_wen0",    {31'd0, bus.RAM_write_en}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Cell 2 = 5: step through the exact timeline.
    mem[22] = 15'o00005;
    bus.core_RAM_write_address = 15'o5;
    clear_logs();
    bus.inc_req = 8'h04;
    tick();
    bus.inc_req = '0;
    check("c2_idle_stall", {31'd0, bus.core_stall}, 32'd0);
    tick();
    check("c2_drain1_stall", {31'd0, bus.core_stall}, 32'd1);
    check("c2_drain_pass",   {17'd0, bus.RAM_write_address}, 32'o5);
    tick();
    check("c2_drain2_stall", {31'd0, bus.core_stall}, 32'd1);
    tick();
    check("c2_read_addr",  {17'd0, bus.RAM_read_address}, 32'o26);
    check("c2_read_wen",   {31'd0, bus.RAM_write_en}, 32'd0);
    check("c2_read_stall", {31'd0, bus.core_stall}, 32'd1);
    tick();
    check("c2_write_wen",  {31'd0, bus.RAM_write_en}, 32'd1);
    check("c2_write_addr", {17'd0, bus.RAM_write_address}, 32'o26);
    check("c2_write_data", {17'd0, bus.RAM_write_data}, 32'o6);
    check("c2_write_rupt", {24'd0, bus.rupt_req}, 32'd0);
    tick();
    check("c2_after_stall", {31'd0, bus.core_stall}, 32'd0);
    check("c2_mem", {17'd0, mem[22]}, 32'o6);
    check("c2_nwrites", wq_addr.size(), 32'd1);

    // Cell 1 overflow cascades into cell 0 without re-draining.
    mem[21] = 15'o37777;
    mem[20] = 15'o00010;
    clear_logs();
    service(8'h02, stalls, timeout);
    check("casc_timeout", {31'd0, timeout}, 32'd0);
    check("casc_stalls", stalls, 32'd6);
    check("casc_mem1", {17'd0, mem[21]}, 32'o0);
    check("casc_mem0", {17'd0, mem[20]}, 32'o11);
    check("casc_nwrites", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      check("casc_first_addr",  {17'd0, wq_addr[0]}, 32'o25);
      check("casc_second_addr", {17'd0, wq_addr[1]}, 32'o24);
    end
    check("casc_nrupt", rq.size(), 32'd1);
    if (rq.size() == 1) check("casc_rupt", {24'd0, rq[0]}, 32'h02);

    // Minus zero steps to plus one.
    mem[23] = 15'o77777;
    clear_logs();
    service(8'h08, stalls, timeout);
    check("negz_timeout", {31'd0, timeout}, 32'd0);
    check("negz_stalls", stalls, 32'd4);
    check("negz_mem", {17'd0, mem[23]}, 32'o1);
    check("negz_nrupt", rq.size(), 32'd0);

    // Two simultaneous requests: lowest index first, one continuous stall.
    mem[24] = 15'd7;
    mem[25] = 15'd100;
    clear_logs();
    service(8'h30, stalls, timeout);
    check("pair_timeout", {31'd0, timeout}, 32'd0);
    check("pair_stalls", stalls, 32'd6);
    check("pair_nwrites", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      check("pair_first_addr",  {17'd0, wq_addr[0]}, 32'o30);
      check("pair_second_addr", {17'd0, wq_addr[1]}, 32'o31);
    end
    check("pair_mem4", {17'd0, mem[24]}, 32'd8);
    check("pair_mem5", {17'd0, mem[25]}, 32'd101);

    // Coalesced request sets overrun; a pulse on the READ-entry edge survives.
    mem[26] = 15'd0;
    clear_logs();
    bus.inc_req = 8'h40;
    tick();
    bus.inc_req = 8'h40;
    tick();
    bus.inc_req = '0;
    check("ovr_flag", {24'd0, bus.overrun}, 32'h40);
    tick();
    bus.inc_req = 8'h40;
    tick();
    bus.inc_req = '0;
    check("ovr_read_stall", {31'd0, bus.core_stall}, 32'd1);
    timeout = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!bus.core_stall) begin
        timeout = 1'b0;
        break;
      end
    end
    check("ovr_timeout", {31'd0, timeout}, 32'd0);
    check("ovr_nwrites", wq_addr.size(), 32'd2);
    check("ovr_mem", {17'd0, mem[26]}, 32'd2);
    check("ovr_sticky", {24'd0, bus.overrun}, 32'h40);

    // Reset asserted during WRITE abandons the write.
    mem[27] = 15'd5;
    bus.core_RAM_write_address = 15'o2;
    bus.core_RAM_write_data    = 15'o4321;
    clear_logs();
    bus.inc_req = 8'h80;
    tick();
    bus.inc_req = '0;
    tick();
    tick();
    tick();
    tick();
    check("rw_in_write", {31'd0, bus.RAM_write_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rw_wen_core0", {31'd0, bus.RAM_write_en}, 32'd0);
    check("rw_stall",     {31'd0, bus.core_stall}, 32'd0);
    bus.core_RAM_write_en = 1'b1;
    #1;
    check("rw_wen_core1", {31'd0, bus.RAM_write_en}, 32'd1);
    check("rw_waddr",     {17'd0, bus.RAM_write_address}, 32'o2);
    check("rw_wdata",     {17'd0, bus.RAM_write_data}, 32'o4321);
    tick();
    reset_n = 1'b1;
    bus.core_RAM_write_en = 1'b0;
    check("rw_post_stall", {31'd0, bus.core_stall}, 32'd0);
    check("rw_overrun",    {24'd0, bus.overrun}, 32'd0);
    stalls = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (bus.core_stall) stalls++;
    end
    check("rw_no_service", stalls, 32'd0);
    check("rw_mem_kept", {17'd0, mem[27]}, 32'd5);
    check("rw_nwrites", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) check("rw_core_write_addr", {17'd0, wq_addr[0]}, 32'o2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 15'o24: RAM address of counter cell 0; cell i lives at BASE_ADDR+i.
REQ-002 Parameter NCNT, default 8: number of counter cells.
REQ-003 Parameter DRAIN_CYCLES, default 2: stall cycles granted to the core pipeline before the first memory cycle is stolen.
REQ-004 Parameter CASCADE_SRC, default 1, and CASCADE_DST, default 0: overflow of cell CASCADE_SRC posts an increment request on cell CASCADE_DST.
REQ-005 The block has one clock. Reset is synchronous and active-low.
REQ-006 clock  in  1  system clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 inc_req  in  NCNT  one-cycle increment request pulse per cell.
REQ-009 core_RAM_read_address, core_RAM_write_address, core_RAM_write_data  in  15 each  core-side RAM port.
REQ-010 core_RAM_write_en  in  1  core-side write enable.
REQ-011 RAM_read_data  in  15  combinational read data from RAM.
REQ-012 RAM_read_address, RAM_write_address, RAM_write_data  out  15 each  arbitrated RAM port.
REQ-013 RAM_write_en  out  1  arbitrated write enable.
REQ-014 core_stall  out  1  freezes the core pipeline while high.
REQ-015 rupt_req  out  NCNT  one-cycle overflow pulse per cell.
REQ-016 overrun  out  NCNT  sticky flag per cell: an increment was coalesced.

Function
REQ-017 The FSM SHALL have the states IDLE, DRAIN, READ and WRITE.
REQ-018 IDLE: RAM outputs SHALL mirror the core inputs combinationally and core_stall=0. If any pending bit is set, the next state is DRAIN and the drain counter loads DRAIN_CYCLES.
REQ-019 DRAIN: core_stall=1 and the RAM port passes the core through, so in-flight writebacks complete. The counter decrements each cycle; when it reaches 0 the next state is READ.
REQ-020 READ: core_stall=1 and RAM_read_address=BASE_ADDR+sel. RAM_write_en=0. RAM_read_data is captured into the operand register at the end of the cycle.
REQ-021 WRITE: core_stall=1 and RAM_write_address=BASE_ADDR+sel. RAM_write_data=inc(operand) and RAM_write_en=1.
REQ-022 Leaving WRITE: if any pending bit is set, the next state is READ directly (no re-drain); otherwise the next state is IDLE.
REQ-023 Selection SHALL be fixed priority, lowest index first. sel is latched on the transition into READ, and the selected pending bit is cleared on that same edge.
REQ-024 inc() SHALL use 15-bit ones' complement with the sign in bit 14:
- operand 15'o37777 gives 15'o00000 with overflow=1.
- operand 15'o77777 (-0) gives 15'o00001.
- any other operand gives operand+1 modulo 2^15, with overflow=0.
REQ-025 Overflow SHALL pulse rupt_req[sel] for exactly the WRITE cycle.
REQ-026 When sel==CASCADE_SRC and overflow=1, pending[CASCADE_DST] SHALL be set on the WRITE edge.
REQ-027 inc_req[i] SHALL set pending[i]. If pending[i] is already set and not being cleared that cycle, overrun[i] SHALL set and the request coalesces.
REQ-028 When a clear of pending[i] (REQ-023) coincides with inc_req[i], pending[i] SHALL remain 1 and overrun is unchanged.
REQ-029 Latency from an isolated inc_req to the RAM write SHALL be 1+DRAIN_CYCLES+2 cycles. The write occurs in WRITE, and core_stall falls one cycle after WRITE.
REQ-030 Back-to-back service SHALL cost 2 cycles per additional cell.
REQ-031 overrun bits SHALL clear only on reset.

Reset
REQ-032 On a clock edge with reset_n=0 the block SHALL:
- force the state to IDLE;
- clear pending, overrun, the operand register, sel and the drain counter;
- drive core_stall=0, rupt_req=0 and RAM_write_en=core_RAM_write_en.
REQ-033 A reset asserted in READ or WRITE SHALL abandon the cycle. No RAM write occurs on or after the reset edge, and the request is lost.

Verification
REQ-034 Cell 2 holds 15'o00005 and inc_req[2] pulses -> core_stall high for 4 cycles, then 15'o00006 written to 15'o26, rupt_req=0.
REQ-035 Cell 1 holds 15'o37777 and cell 0 holds 15'o00010, inc_req[1] pulses -> cell 1 becomes 15'o00000 with rupt_req[1] pulsed; cell 0 becomes 15'o00011 in the following READ/WRITE pair with no re-drain; rupt_req[0]=0.
REQ-036 Cell 3 holds 15'o77777 and inc_req[3] pulses -> 15'o00001 is written.
REQ-037 inc_req[5] and inc_req[4] pulse in the same cycle -> cell 4 is serviced first, then cell 5; core_stall is continuous for 6 cycles.
REQ-038 inc_req[6] pulses twice while pending is set -> one increment and overrun[6]=1; a third pulse coinciding with the READ-entry edge yields a second increment.
REQ-039 reset_n low during WRITE -> RAM_write_en=core_RAM_write_en; core_stall=0, pending=0 and the state is IDLE on the next cycle.
